// File: rtl/nios_system_sysid_checker.sv
// Boot-time system-ID check: reads sysid words 0/1 over Avalon-MM, compares, gates the datapath.
// Bounded retries with idle gaps and a per-read stall timeout; sticky pass/fail until the next run.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1674985676,
    parameter int          MAX_RETRIES        = 3,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          RETRY_GAP          = 16,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        id_ok,
    output logic        id_fail,
    output logic        datapath_enable,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp,
    output logic [2:0]  attempt_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ID, S_RD_TS, S_CMP, S_GAP, S_PASS, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] stall_q, stall_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [RW-1:0] tries_q, tries_d;
    logic [2:0]    attempt_q, attempt_d;
    logic          id_ok_q, id_ok_d;
    logic          id_fail_q, id_fail_d;
    logic          dp_en_q, dp_en_d;
    logic [31:0]   cap_id_q, cap_id_d;
    logic [31:0]   cap_ts_q, cap_ts_d;
    logic          auto_pend_q, auto_pend_d;

    logic accept, timeout, launch, attempt_bad;

    // Bus strobes decode straight from state so an async reset drops them immediately.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = avm_read || (state_q == S_CMP) || (state_q == S_GAP);

    assign accept  = avm_read && !avm_waitrequest;
    assign timeout = avm_read && avm_waitrequest && (stall_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        gap_d       = gap_q;
        tries_d     = tries_q;
        attempt_d   = attempt_q;
        id_ok_d     = id_ok_q;
        id_fail_d   = id_fail_q;
        dp_en_d     = dp_en_q;
        cap_id_d    = cap_id_q;
        cap_ts_d    = cap_ts_q;
        auto_pend_d = auto_pend_q;
        launch      = 1'b0;
        attempt_bad = 1'b0;

        case (state_q)
            S_IDLE: begin
                auto_pend_d = 1'b0;
                launch      = start || auto_pend_q;
            end
            S_RD_ID: begin
                if (accept) begin
                    cap_id_d = avm_readdata;
                    stall_d  = '0;
                    state_d  = S_RD_TS;
                end else if (timeout) begin
                    attempt_bad = 1'b1;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
            S_RD_TS: begin
                if (accept) begin
                    cap_ts_d = avm_readdata;
                    stall_d  = '0;
                    state_d  = S_CMP;
                end else if (timeout) begin
                    attempt_bad = 1'b1;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
            S_CMP: begin
                if (cap_id_q == EXPECTED_ID && cap_ts_q == EXPECTED_TIMESTAMP) begin
                    id_ok_d = 1'b1;
                    dp_en_d = 1'b1;
                    state_d = S_PASS;
                end else begin
                    attempt_bad = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(RETRY_GAP - 1)) begin
                    stall_d   = '0;
                    tries_d   = tries_q + RW'(1);
                    attempt_d = (attempt_q == 3'd7) ? attempt_q : attempt_q + 3'd1;
                    state_d   = S_RD_ID;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_PASS, S_FAIL: launch = start;
            default: state_d = S_IDLE;
        endcase

        // tries_q counts attempts already made, including the one that just failed.
        if (attempt_bad) begin
            if (tries_q <= RW'(MAX_RETRIES)) begin
                gap_d   = '0;
                state_d = S_GAP;
            end else begin
                id_fail_d = 1'b1;
                state_d   = S_FAIL;
            end
        end

        if (launch) begin
            id_ok_d   = 1'b0;
            id_fail_d = 1'b0;
            dp_en_d   = 1'b0;
            stall_d   = '0;
            tries_d   = RW'(1);
            attempt_d = 3'd1;
            state_d   = S_RD_ID;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            stall_q     <= '0;
            gap_q       <= '0;
            tries_q     <= '0;
            attempt_q   <= '0;
            id_ok_q     <= 1'b0;
            id_fail_q   <= 1'b0;
            dp_en_q     <= 1'b0;
            cap_id_q    <= '0;
            cap_ts_q    <= '0;
            auto_pend_q <= AUTO_START;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            gap_q       <= gap_d;
            tries_q     <= tries_d;
            attempt_q   <= attempt_d;
            id_ok_q     <= id_ok_d;
            id_fail_q   <= id_fail_d;
            dp_en_q     <= dp_en_d;
            cap_id_q    <= cap_id_d;
            cap_ts_q    <= cap_ts_d;
            auto_pend_q <= auto_pend_d;
        end
    end

    assign id_ok              = id_ok_q;
    assign id_fail            = id_fail_q;
    assign datapath_enable    = dp_en_q;
    assign captured_id        = cap_id_q;
    assign captured_timestamp = cap_ts_q;
    assign attempt_count      = attempt_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench: sysid slave model with configurable stalls and bad data, hand-computed cycle counts.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1674985676;
    localparam logic [31:0] BAD_TS = 32'h1234_5678;
    localparam logic [31:0] BAD_ID = 32'hDEAD_0001;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, id_ok, id_fail, datapath_enable;
    logic [31:0] captured_id, captured_timestamp;
    logic [2:0]  attempt_count;

    int checks = 0;
    int errors = 0;

    // Slave model controls, written only by the stimulus process.
    bit stuck     = 1'b0;
    bit rand_wait = 1'b0;
    int fixed_wait = 0;
    int ts_bad_until = 0;
    int id_bad_until = 0;

    // Monitor state, written only by the monitor process.
    int   ts_reads = 0, id_reads = 0, rd_starts = 0, run = 0, max_run = 0, addr_viol = 0;
    logic prev_rdwait = 1'b0, prev_addr = 1'b0, prev_read = 1'b0;
    logic [2:0] stall_left = 3'd0;

    always #5 clock = ~clock;

    nios_system_sysid_checker #(.TIMEOUT_CYCLES(8)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .busy               (busy),
        .id_ok              (id_ok),
        .id_fail            (id_fail),
        .datapath_enable    (datapath_enable),
        .captured_id        (captured_id),
        .captured_timestamp (captured_timestamp),
        .attempt_count      (attempt_count)
    );

    assign avm_waitrequest = stuck || (stall_left != 3'd0);
    assign avm_readdata = avm_address ? ((ts_reads < ts_bad_until) ? BAD_TS : EXP_TS)
                                      : ((id_reads < id_bad_until) ? BAD_ID : 32'd0);

    function automatic logic [2:0] next_stall();
        return rand_wait ? 3'($urandom_range(0, 5)) : 3'(fixed_wait);
    endfunction

    always @(posedge clock) begin
        if (!avm_read || !avm_waitrequest) stall_left <= next_stall();
        else                               stall_left <= stall_left - 3'd1;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address) ts_reads <= ts_reads + 1;
            else             id_reads <= id_reads + 1;
        end
        if (avm_read && !prev_read && !avm_address) rd_starts <= rd_starts + 1;
        if (prev_rdwait && avm_read && (avm_address != prev_addr)) addr_viol <= addr_viol + 1;
        run <= avm_read ? run + 1 : 0;
        if (avm_read && run + 1 > max_run) max_run <= run + 1;
        prev_rdwait <= avm_read && avm_waitrequest;
        prev_addr   <= avm_address;
        prev_read   <= avm_read;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Optionally pulse start, then count clock cycles until busy falls.
    task automatic run_check(input bit pulse, output int cyc);
        start = pulse;
        cyc = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
        end while (busy && cyc < 3000);
        chk_eq("run_finished_in_budget", 32'(busy), 32'd0);
    endtask

    int cyc, starts0, w;

    initial begin
        // Reset state
        #3;
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_read", 32'(avm_read), 0);
        chk_eq("rst_id_ok", 32'(id_ok), 0);
        chk_eq("rst_dp_en", 32'(datapath_enable), 0);
        chk_eq("rst_attempts", 32'(attempt_count), 0);

        // 1: auto-start, zero-wait slave, pass 4 cycles after release
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk_eq("t1_id_ok_cyc3", 32'(id_ok), 0);
        @(negedge clock);
        chk_eq("t1_id_ok_cyc4", 32'(id_ok), 1);
        chk_eq("t1_dp_en", 32'(datapath_enable), 1);
        chk_eq("t1_id_fail", 32'(id_fail), 0);
        chk_eq("t1_attempts", 32'(attempt_count), 1);
        chk_eq("t1_cap_ts", captured_timestamp, EXP_TS);
        chk_eq("t1_busy", 32'(busy), 0);

        // 2: timestamp always wrong -> 4 attempts, 3 gaps of 16, fail at cycle 61
        ts_bad_until = ts_reads + 1000;
        starts0 = rd_starts;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk_eq("t2_rerun_clears_ok", 32'(id_ok), 0);
        chk_eq("t2_busy", 32'(busy), 1);
        chk_eq("t2_first_attempt", 32'(attempt_count), 1);
        run_check(1'b0, cyc);
        chk_eq("t2_cycles", 32'(cyc + 1), 61);
        chk_eq("t2_id_fail", 32'(id_fail), 1);
        chk_eq("t2_id_ok", 32'(id_ok), 0);
        chk_eq("t2_dp_en", 32'(datapath_enable), 0);
        chk_eq("t2_cap_ts", captured_timestamp, BAD_TS);
        chk_eq("t2_attempts", 32'(attempt_count), 4);
        chk_eq("t2_read_starts", 32'(rd_starts - starts0), 4);

        // 3: ID wrong on attempt 1, timestamp wrong on attempts 1-2, good on 3
        id_bad_until = id_reads + 1;
        ts_bad_until = ts_reads + 2;
        run_check(1'b1, cyc);
        chk_eq("t3_cycles", 32'(cyc), 42);
        chk_eq("t3_id_ok", 32'(id_ok), 1);
        chk_eq("t3_id_fail", 32'(id_fail), 0);
        chk_eq("t3_attempts", 32'(attempt_count), 3);
        chk_eq("t3_cap_id", captured_id, 0);

        // 4: waitrequest stuck high -> 8-cycle read bursts, fail at cycle 81
        stuck = 1'b1;
        starts0 = rd_starts;
        run_check(1'b1, cyc);
        chk_eq("t4_cycles", 32'(cyc), 81);
        chk_eq("t4_id_fail", 32'(id_fail), 1);
        chk_eq("t4_attempts", 32'(attempt_count), 4);
        chk_eq("t4_longest_read", 32'(max_run), 8);
        chk_eq("t4_read_starts", 32'(rd_starts - starts0), 4);
        chk_eq("t4_read_low", 32'(avm_read), 0);
        stuck = 1'b0;

        // 5: random 0-5 stall cycles per read, good data
        rand_wait = 1'b1;
        run_check(1'b1, cyc);
        chk_eq("t5_id_ok", 32'(id_ok), 1);
        chk_eq("t5_attempts", 32'(attempt_count), 1);
        chk_eq("t5_cap_ts", captured_timestamp, EXP_TS);
        chk_eq("t5_addr_stable", 32'(addr_viol), 0);
        rand_wait = 1'b0;

        // 6: start ignored while busy, async reset during RD_TS, rerun after pass
        fixed_wait = 3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        w = 0;
        while (!(avm_read && avm_address) && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk_eq("t6_reached_rd_ts", 32'(avm_read && avm_address), 1);
        chk_eq("t6_busy_start_ignored", 32'(attempt_count), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("t6_rst_read", 32'(avm_read), 0);
        chk_eq("t6_rst_busy", 32'(busy), 0);
        chk_eq("t6_rst_cap_id", captured_id, 0);
        chk_eq("t6_rst_attempts", 32'(attempt_count), 0);
        chk_eq("t6_rst_dp_en", 32'(datapath_enable), 0);
        fixed_wait = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk_eq("t6_auto_pass", 32'(id_ok), 1);
        repeat (2) @(negedge clock);
        chk_eq("t6_no_queued_start", 32'(id_ok), 1);
        chk_eq("t6_idle_after_pass", 32'(busy), 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk_eq("t6_restart_clears", 32'(id_ok), 0);
        run_check(1'b0, cyc);
        chk_eq("t6_rerun_pass", 32'(id_ok), 1);
        chk_eq("t6_addr_stable", 32'(addr_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
